// File: rtl/encoder_position_tracker.sv
// Signed position counter and windowed velocity estimator fed by a quadrature direction decoder.
// Position reflects dir on the sampling edge; velocity and its one-cycle strobe update every WINDOW clocks.
module encoder_position_tracker #(
  parameter int POS_WIDTH = 16,
  parameter int VEL_WIDTH = 12,
  parameter int WINDOW    = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           dir,
  input  logic                 clear,
  input  logic                 load,
  input  logic [POS_WIDTH-1:0] load_value,
  output logic [POS_WIDTH-1:0] position,
  output logic [VEL_WIDTH-1:0] velocity,
  output logic                 vel_valid,
  output logic [1:0]           last_dir,
  output logic                 dir_error,
  output logic                 wrap
);

  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);
  localparam logic [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};
  localparam logic [VEL_WIDTH-1:0] VEL_MAX = {1'b0, {(VEL_WIDTH-1){1'b1}}};
  localparam logic [VEL_WIDTH-1:0] VEL_MIN = {1'b1, {(VEL_WIDTH-1){1'b0}}};

  logic                 step_up;
  logic                 step_dn;
  logic [POS_WIDTH-1:0] pos_step;
  logic [VEL_WIDTH:0]   vel_step;
  logic [VEL_WIDTH:0]   acc_sum;
  logic [VEL_WIDTH-1:0] acc_sat;
  logic [VEL_WIDTH-1:0] acc;
  logic [CW-1:0]        cnt;
  logic                 pos_ovf;

  assign step_up  = (dir == 2'b01);
  assign step_dn  = (dir == 2'b10);
  // Sign-extended +1 / -1 / 0 without a multiplier or mux tree.
  assign pos_step = {{(POS_WIDTH-1){step_dn}}, step_up | step_dn};
  assign vel_step = {{VEL_WIDTH{step_dn}}, step_up | step_dn};
  assign acc_sum  = {acc[VEL_WIDTH-1], acc} + vel_step;
  assign pos_ovf  = (step_up && position == POS_MAX) || (step_dn && position == POS_MIN);

  // One extra bit of headroom: the top two bits disagree exactly on overflow.
  always_comb begin
    acc_sat = acc_sum[VEL_WIDTH-1:0];
    if (acc_sum[VEL_WIDTH] != acc_sum[VEL_WIDTH-1])
      acc_sat = acc_sum[VEL_WIDTH] ? VEL_MIN : VEL_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position  <= '0;
      last_dir  <= 2'b00;
      dir_error <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      if (step_up || step_dn)
        last_dir <= dir;
      if (load) begin
        position <= load_value;
      end else if (clear) begin
        position  <= '0;
        dir_error <= 1'b0;
        wrap      <= 1'b0;
      end else begin
        position <= position + pos_step;
        if (pos_ovf)
          wrap <= 1'b1;
        if (dir == 2'b11)
          dir_error <= 1'b1;
      end
    end
  end

  // Velocity window runs independently of host clear/load so it tracks real motion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (cnt == CNT_LAST) begin
        cnt       <= '0;
        acc       <= '0;
        velocity  <= acc_sat;
        vel_valid <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
        acc <= acc_sat;
      end
    end
  end

endmodule

// File: tb/tb_encoder_position_tracker.sv
// Directed vector bench: per-cycle table on a WINDOW=10 instance, plus reset and saturation sequences.
module tb_encoder_position_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  dir = 2'b00;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] position;
  logic [11:0] velocity;
  logic        vel_valid;
  logic [1:0]  last_dir;
  logic        dir_error;
  logic        wrap;

  logic        rst2_n = 1'b0;
  logic [1:0]  dir2 = 2'b00;
  logic        zero = 1'b0;
  logic [15:0] zero16 = '0;
  logic [15:0] position2;
  logic [3:0]  velocity2;
  logic        vel_valid2;
  logic [1:0]  last_dir2;
  logic        dir_error2;
  logic        wrap2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  encoder_position_tracker #(.POS_WIDTH(16), .VEL_WIDTH(12), .WINDOW(10)) dut (
    .clk(clk), .rst_n(rst_n), .dir(dir), .clear(clear), .load(load), .load_value(load_value),
    .position(position), .velocity(velocity), .vel_valid(vel_valid), .last_dir(last_dir),
    .dir_error(dir_error), .wrap(wrap)
  );

  encoder_position_tracker #(.POS_WIDTH(16), .VEL_WIDTH(4), .WINDOW(20)) dut_sat (
    .clk(clk), .rst_n(rst2_n), .dir(dir2), .clear(zero), .load(zero), .load_value(zero16),
    .position(position2), .velocity(velocity2), .vel_valid(vel_valid2), .last_dir(last_dir2),
    .dir_error(dir_error2), .wrap(wrap2)
  );

  typedef struct {
    logic [1:0]  dir;
    logic        clr;
    logic        ld;
    logic [15:0] lv;
    logic [15:0] pos;
    logic [1:0]  ldir;
    logic        err;
    logic        wrp;
    logic        vv;
    logic [11:0] vel;
  } vec_t;

  vec_t tbl[64];
  int   nt = 0;

  task automatic add(input logic [1:0] d, input logic c, input logic l, input logic [15:0] lv,
                     input logic [15:0] p, input logic [1:0] ldr, input logic e, input logic w,
                     input logic vv, input logic [11:0] v);
    tbl[nt] = '{d, c, l, lv, p, ldr, e, w, vv, v};
    nt++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] p, input logic [1:0] ldr,
                         input logic e, input logic w, input logic vv, input logic [11:0] v);
    chk({tag, ".position"}, 32'(position), 32'(p));
    chk({tag, ".last_dir"}, 32'(last_dir), 32'(ldr));
    chk({tag, ".dir_error"}, 32'(dir_error), 32'(e));
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
    chk({tag, ".vel_valid"}, 32'(vel_valid), 32'(vv));
    chk({tag, ".velocity"}, 32'(velocity), 32'(v));
  endtask

  initial begin
    // Rows are cycles counted from reset release; windows close on rows 9, 19, 29, 39.
    add(2'b01,0,0,16'h0,    16'h0001,2'b01,0,0,0,12'd0);
    add(2'b01,0,0,16'h0,    16'h0002,2'b01,0,0,0,12'd0);
    add(2'b01,0,0,16'h0,    16'h0003,2'b01,0,0,0,12'd0);
    add(2'b00,0,0,16'h0,    16'h0003,2'b01,0,0,0,12'd0);
    add(2'b11,0,0,16'h0,    16'h0003,2'b01,1,0,0,12'd0);
    add(2'b10,0,0,16'h0,    16'h0002,2'b10,1,0,0,12'd0);
    for (int i = 6; i < 9; i++) add(2'b00,0,0,16'h0,16'h0002,2'b10,1,0,0,12'd0);
    add(2'b00,0,0,16'h0,    16'h0002,2'b10,1,0,1,12'd2);
    add(2'b00,1,0,16'h0,    16'h0000,2'b10,0,0,0,12'd2);
    add(2'b00,0,1,16'h7FFE, 16'h7FFE,2'b10,0,0,0,12'd2);
    add(2'b01,0,0,16'h0,    16'h7FFF,2'b01,0,0,0,12'd2);
    add(2'b01,0,0,16'h0,    16'h8000,2'b01,0,1,0,12'd2);
    add(2'b01,0,0,16'h0,    16'h8001,2'b01,0,1,0,12'd2);
    add(2'b11,0,0,16'h0,    16'h8001,2'b01,1,1,0,12'd2);
    add(2'b01,1,1,16'd100,  16'd100, 2'b01,1,1,0,12'd2);
    add(2'b00,1,0,16'h0,    16'h0000,2'b01,0,0,0,12'd2);
    add(2'b10,0,0,16'h0,    16'hFFFF,2'b10,0,0,0,12'd2);
    add(2'b00,0,0,16'h0,    16'hFFFF,2'b10,0,0,1,12'd3);
    for (int i = 20; i < 29; i++) add(2'b00,0,0,16'h0,16'hFFFF,2'b10,0,0,0,12'd3);
    add(2'b00,0,0,16'h0,    16'hFFFF,2'b10,0,0,1,12'd0);
    add(2'b00,0,1,16'h8000, 16'h8000,2'b10,0,0,0,12'd0);
    add(2'b10,0,0,16'h0,    16'h7FFF,2'b10,0,1,0,12'd0);
    add(2'b11,0,0,16'h0,    16'h7FFF,2'b10,1,1,0,12'd0);
    add(2'b00,1,0,16'h0,    16'h0000,2'b10,0,0,0,12'd0);
    add(2'b11,1,0,16'h0,    16'h0000,2'b10,0,0,0,12'd0);
    add(2'b11,0,0,16'h0,    16'h0000,2'b10,1,0,0,12'd0);
    add(2'b00,0,0,16'h0,    16'h0000,2'b10,1,0,0,12'd0);
    add(2'b00,1,0,16'h0,    16'h0000,2'b10,0,0,0,12'd0);
    add(2'b00,0,0,16'h0,    16'h0000,2'b10,0,0,0,12'd0);
    add(2'b00,0,0,16'h0,    16'h0000,2'b10,0,0,1,12'hFFF);

    repeat (3) @(posedge clk);
    #1 chk_all("reset", 16'h0, 2'b00, 0, 0, 0, 12'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < nt; i++) begin
      if (i > 0) @(negedge clk);
      dir = tbl[i].dir; clear = tbl[i].clr; load = tbl[i].ld; load_value = tbl[i].lv;
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), tbl[i].pos, tbl[i].ldir, tbl[i].err, tbl[i].wrp,
                 tbl[i].vv, tbl[i].vel);
    end

    // Mid-window reset: four steps into a fresh window, then async reset between edges.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dir = 2'b01; clear = 1'b0; load = 1'b0;
      @(posedge clk);
    end
    #1 chk("pre_reset.position", 32'(position), 32'd4);
    @(negedge clk);
    dir = 2'b00;
    #2 rst_n = 1'b0;
    #1 chk_all("async_reset", 16'h0, 2'b00, 0, 0, 0, 12'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      dir = (k < 3) ? 2'b01 : 2'b00;
      @(posedge clk);
      #1 chk($sformatf("restart%0d.vel_valid", k), 32'(vel_valid), (k == 9) ? 32'd1 : 32'd0);
    end
    chk("restart.velocity", 32'(velocity), 32'd3);
    chk("restart.position", 32'(position), 32'd3);
    @(posedge clk);
    #1 chk("restart.pulse_end", 32'(vel_valid), 32'd0);

    // Saturating accumulator on the narrow instance.
    @(negedge clk);
    rst2_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      dir2 = 2'b01;
      @(posedge clk);
      #1 if (k == 18) chk("sat_up.early", 32'(vel_valid2), 32'd0);
    end
    chk("sat_up.vel_valid", 32'(vel_valid2), 32'd1);
    chk("sat_up.velocity", 32'(velocity2), 32'd7);
    chk("sat_up.position", 32'(position2), 32'd20);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      dir2 = 2'b10;
      @(posedge clk);
      #1 if (k == 0) chk("sat_dn.pulse_end", 32'(vel_valid2), 32'd0);
    end
    chk("sat_dn.vel_valid", 32'(vel_valid2), 32'd1);
    chk("sat_dn.velocity", 32'(velocity2), 32'h8);
    chk("sat_dn.position", 32'(position2), 32'd0);
    chk("sat_dn.last_dir", 32'(last_dir2), 32'd2);
    chk("sat_dn.flags", 32'({dir_error2, wrap2}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
